axi_master_compare: RTL and testbench
=====================================

// Module: axi_master_compare
// PURPOSE
//  Lockstep checker for two AXI4+ATOP masters of the same type (DMR cores, duplicated DMAs).
//  Joins the AW/W/AR channels of master A and master B and forwards A's payload to one slave port.
//  Compares A vs B payload at each forwarded handshake, and forks every B/R beat to both masters.
//  Sits between a duplicated master pair and the interconnect, on FPGA or in silicon.
// PARAMETERS
//  MaxTxns       8       max outstanding writes and max outstanding reads (separate counters)
//  TimeoutCycles 1024    consecutive single-sided-valid cycles before timeout; 0 disables
//  axi_aw_chan_t logic   AW channel type (axi_w/b/ar/r_chan_t likewise)
//  axi_req_t     logic   request struct type
//  axi_rsp_t     logic   response struct type
// PORTS
//  clk_i          in   1      clock
//  rst_ni         in   1      asynchronous reset, active low
//  clear_i        in   1      clears all sticky error flags
//  axi_mst_a_req_i in  req_t  master A request (primary; payload forwarded)
//  axi_mst_a_rsp_o out rsp_t  master A response
//  axi_mst_b_req_i in  req_t  master B request (shadow; compared only)
//  axi_mst_b_rsp_o out rsp_t  master B response
//  axi_slv_req_o  out  req_t  downstream request
//  axi_slv_rsp_i  in   rsp_t  downstream response
//  aw_mismatch_o  out  1      sticky: AW payload A!=B at a handshake
//  w_mismatch_o   out  1      sticky: W payload mismatch
//  ar_mismatch_o  out  1      sticky: AR payload mismatch
//  timeout_o      out  3      sticky {ar,w,aw}: one master waited TimeoutCycles on the other
//  mismatch_o     out  1      OR of all mismatch and timeout flags
//  busy_o         out  1      outstanding txn or partially delivered response beat
// BEHAVIOUR
//  Reset: all flags 0, both counters 0, fork-done flops 0, timeout counters 0; outputs idle.
//  Request join (AW, W, AR independently):
//   - slv.x_valid = a.x_valid & b.x_valid & ~cap_block; payload = A's.
//   - a/b.x_ready = slv.x_ready & a.x_valid & b.x_valid & ~cap_block. Both masters handshake together.
//   - No added latency; combinational path valid->valid, ready->ready.
//   - At handshake: full-struct compare a.x != b.x -> x_mismatch_o set next cycle.
//  Outstanding cap:
//   - cap_block is AW-only when wr_cnt==MaxTxns; AR-only when rd_cnt==MaxTxns. W is never blocked.
//   - wr_cnt +1 on AW handshake, -1 when a B beat is delivered to both; simultaneous -> unchanged.
//   - rd_cnt +1 on AR handshake, -1 when an R beat with last=1 is delivered to both.
//   - Width $clog2(MaxTxns+1); never wraps.
//  Response fork (B and R each):
//   - a/b.x_valid = slv.x_valid & ~done_a/~done_b. Payload is slv's for both.
//   - done_a/done_b set on the respective master handshake.
//   - slv.x_ready = (a.x_ready|done_a) & (b.x_ready|done_b); done flops clear on that cycle.
//   - Beats delivered in-order, unmodified; each beat reaches each master exactly once.
//  Timeout (per request channel):
//   - Counter increments while a.x_valid ^ b.x_valid; clears when both or neither are valid.
//   - Reaching TimeoutCycles sets timeout_o[i]; the counter saturates there.
//  Flags: sticky until clear_i. Set and clear_i in the same cycle -> set wins.
//  busy_o = (wr_cnt!=0)|(rd_cnt!=0)|any done flop set|any request valid pending.
//  Reset mid-transaction drops all state; the environment resets masters and slave together.
// STRUCTURE
//  No new package; use existing AXI typedef/assign macros, with local parameters only.
//  Sub-module axi_lockstep_chan #(chan_t, TimeoutCycles): one channel's join + compare + timeout.
//   - Instantiated for AW, W, AR.
//  The B/R forks use the codebase stream_fork (N_OUP=2).
//  Counters and flags stay in top level.
// TESTING
//  1 Both masters issue identical AW id=3 addr=0x1000 len=3 plus 4 W beats -> one slave AW.
//    4 W beats forwarded, one B delivered to both, all flags 0, busy_o low after B.
//  2 B master presents AR addr 0x2004 vs A's 0x2000 -> slave sees 0x2000.
//    ar_mismatch_o=1 and mismatch_o=1 next cycle; clear_i pulse -> both 0.
//  3 A asserts aw_valid, B silent for 1024 cycles (TimeoutCycles=1024) -> timeout_o=3'b001.
//    No slave AW until B asserts.
//  4 R burst len=7: master A ready always, master B ready every 3rd cycle.
//    -> each master receives 8 beats in order; slave r_ready follows the slower master; rd_cnt 1->0.
//  5 MaxTxns=2: issue 3 ARs with slave withholding R -> third AR stalls (ar_ready=0) until the first last-R delivered.
//  6 AW handshake and final B delivery in the same cycle -> wr_cnt unchanged; assert rst_ni low mid-burst -> all outputs reset.

Source files
------------

// File: rtl/axi_master_compare_pkg.sv
// Default AXI4+ATOP channel and request/response types for the lockstep comparator.
// Narrow ID/user widths keep the default build small; real integrations override the type parameters.
package axi_master_compare_pkg;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned UserWidth = 1;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef logic [IdWidth-1:0]   id_t;
  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [StrbWidth-1:0] strb_t;
  typedef logic [UserWidth-1:0] user_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    logic [5:0] atop;
    user_t      user;
  } aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } b_chan_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    user_t      user;
  } ar_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
    user_t      user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } rsp_t;

endpackage

// File: rtl/axi_master_compare_lockstep_chan.sv
// One request channel of the lockstep pair: joins A (primary) and B (shadow) valids,
// flags payload divergence at the handshake and detects one master waiting on the other.
module axi_lockstep_chan #(
  parameter type         chan_t        = logic,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  a_valid,
  input  chan_t a_chan,
  input  logic  b_valid,
  input  chan_t b_chan,
  input  logic  block,
  input  logic  slv_ready,
  output logic  slv_valid,
  output logic  a_ready,
  output logic  b_ready,
  output logic  handshake,
  output logic  mismatch,
  output logic  timeout
);

  logic joined;
  logic single;

  assign joined    = a_valid & b_valid & ~block;
  assign slv_valid = joined;
  assign handshake = slv_ready & joined;
  assign a_ready   = handshake;
  assign b_ready   = handshake;
  assign mismatch  = handshake & (a_chan != b_chan);
  assign single    = a_valid ^ b_valid;

  if (TimeoutCycles == 0) begin : g_no_timeout
    assign timeout = 1'b0;
  end else begin : g_timeout
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] Limit = CntW'(TimeoutCycles);

    logic [CntW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (!single) begin
        cnt <= '0;
      end else if (cnt != Limit) begin
        cnt <= cnt + 1'b1;
      end
    end

    // Asserted during the cycle whose edge brings the count to the limit, so the
    // sticky flag lands exactly TimeoutCycles single-sided cycles after the stall began.
    assign timeout = single & (cnt >= Limit - 1'b1);
  end

endmodule

// File: rtl/axi_master_compare.sv
// Lockstep checker for a duplicated AXI4+ATOP master pair: joins and compares AW/W/AR,
// forwards master A's payload downstream and forks every B/R beat to both masters.
module axi_master_compare
  import axi_master_compare_pkg::*;
#(
  parameter int unsigned MaxTxns       = 8,
  parameter int unsigned TimeoutCycles = 1024,
  parameter type         axi_aw_chan_t = aw_chan_t,
  parameter type         axi_w_chan_t  = w_chan_t,
  parameter type         axi_b_chan_t  = b_chan_t,
  parameter type         axi_ar_chan_t = ar_chan_t,
  parameter type         axi_r_chan_t  = r_chan_t,
  parameter type         axi_req_t     = req_t,
  parameter type         axi_rsp_t     = rsp_t
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  axi_req_t   axi_mst_a_req_i,
  output axi_rsp_t   axi_mst_a_rsp_o,
  input  axi_req_t   axi_mst_b_req_i,
  output axi_rsp_t   axi_mst_b_rsp_o,
  output axi_req_t   axi_slv_req_o,
  input  axi_rsp_t   axi_slv_rsp_i,
  output logic       aw_mismatch_o,
  output logic       w_mismatch_o,
  output logic       ar_mismatch_o,
  output logic [2:0] timeout_o,
  output logic       mismatch_o,
  output logic       busy_o
);

  localparam int unsigned CntW = $clog2(MaxTxns + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxTxns);

  logic [CntW-1:0] wr_cnt, rd_cnt;
  logic            aw_block, ar_block;
  logic            aw_valid, aw_ready_a, aw_ready_b, aw_hs, aw_mm;
  logic            w_valid, w_ready_a, w_ready_b, w_hs, w_mm;
  logic            ar_valid, ar_ready_a, ar_ready_b, ar_hs, ar_mm;
  logic [2:0]      timeout_hit;

  logic            b_done_a, b_done_b, b_to_a, b_to_b, b_slv_ready, b_deliver;
  logic            r_done_a, r_done_b, r_to_a, r_to_b, r_slv_ready, r_deliver;
  axi_b_chan_t     b_beat;
  axi_r_chan_t     r_beat;

  assign aw_block = (wr_cnt == CntMax);
  assign ar_block = (rd_cnt == CntMax);

  axi_lockstep_chan #(.chan_t(axi_aw_chan_t), .TimeoutCycles(TimeoutCycles)) i_aw (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .a_valid   (axi_mst_a_req_i.aw_valid),
    .a_chan    (axi_mst_a_req_i.aw),
    .b_valid   (axi_mst_b_req_i.aw_valid),
    .b_chan    (axi_mst_b_req_i.aw),
    .block     (aw_block),
    .slv_ready (axi_slv_rsp_i.aw_ready),
    .slv_valid (aw_valid),
    .a_ready   (aw_ready_a),
    .b_ready   (aw_ready_b),
    .handshake (aw_hs),
    .mismatch  (aw_mm),
    .timeout   (timeout_hit[0])
  );

  axi_lockstep_chan #(.chan_t(axi_w_chan_t), .TimeoutCycles(TimeoutCycles)) i_w (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .a_valid   (axi_mst_a_req_i.w_valid),
    .a_chan    (axi_mst_a_req_i.w),
    .b_valid   (axi_mst_b_req_i.w_valid),
    .b_chan    (axi_mst_b_req_i.w),
    .block     (1'b0),
    .slv_ready (axi_slv_rsp_i.w_ready),
    .slv_valid (w_valid),
    .a_ready   (w_ready_a),
    .b_ready   (w_ready_b),
    .handshake (w_hs),
    .mismatch  (w_mm),
    .timeout   (timeout_hit[1])
  );

  axi_lockstep_chan #(.chan_t(axi_ar_chan_t), .TimeoutCycles(TimeoutCycles)) i_ar (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .a_valid   (axi_mst_a_req_i.ar_valid),
    .a_chan    (axi_mst_a_req_i.ar),
    .b_valid   (axi_mst_b_req_i.ar_valid),
    .b_chan    (axi_mst_b_req_i.ar),
    .block     (ar_block),
    .slv_ready (axi_slv_rsp_i.ar_ready),
    .slv_valid (ar_valid),
    .a_ready   (ar_ready_a),
    .b_ready   (ar_ready_b),
    .handshake (ar_hs),
    .mismatch  (ar_mm),
    .timeout   (timeout_hit[2])
  );

  // Response forks: a beat retires downstream only once both masters have taken it.
  assign b_beat      = axi_slv_rsp_i.b;
  assign b_to_a      = axi_slv_rsp_i.b_valid & ~b_done_a;
  assign b_to_b      = axi_slv_rsp_i.b_valid & ~b_done_b;
  assign b_slv_ready = (axi_mst_a_req_i.b_ready | b_done_a) & (axi_mst_b_req_i.b_ready | b_done_b);
  assign b_deliver   = axi_slv_rsp_i.b_valid & b_slv_ready;

  assign r_beat      = axi_slv_rsp_i.r;
  assign r_to_a      = axi_slv_rsp_i.r_valid & ~r_done_a;
  assign r_to_b      = axi_slv_rsp_i.r_valid & ~r_done_b;
  assign r_slv_ready = (axi_mst_a_req_i.r_ready | r_done_a) & (axi_mst_b_req_i.r_ready | r_done_b);
  assign r_deliver   = axi_slv_rsp_i.r_valid & r_slv_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_done_a <= 1'b0;
      b_done_b <= 1'b0;
      r_done_a <= 1'b0;
      r_done_b <= 1'b0;
    end else begin
      if (b_deliver) begin
        b_done_a <= 1'b0;
        b_done_b <= 1'b0;
      end else begin
        b_done_a <= b_done_a | (b_to_a & axi_mst_a_req_i.b_ready);
        b_done_b <= b_done_b | (b_to_b & axi_mst_b_req_i.b_ready);
      end
      if (r_deliver) begin
        r_done_a <= 1'b0;
        r_done_b <= 1'b0;
      end else begin
        r_done_a <= r_done_a | (r_to_a & axi_mst_a_req_i.r_ready);
        r_done_b <= r_done_b | (r_to_b & axi_mst_b_req_i.r_ready);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (aw_hs && !b_deliver && wr_cnt != CntMax) begin
        wr_cnt <= wr_cnt + 1'b1;
      end else if (!aw_hs && b_deliver && wr_cnt != '0) begin
        wr_cnt <= wr_cnt - 1'b1;
      end
      if (ar_hs && !(r_deliver && r_beat.last) && rd_cnt != CntMax) begin
        rd_cnt <= rd_cnt + 1'b1;
      end else if (!ar_hs && r_deliver && r_beat.last && rd_cnt != '0) begin
        rd_cnt <= rd_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_mismatch_o <= 1'b0;
      w_mismatch_o  <= 1'b0;
      ar_mismatch_o <= 1'b0;
      timeout_o     <= '0;
    end else begin
      aw_mismatch_o <= aw_mm | (aw_mismatch_o & ~clear_i);
      w_mismatch_o  <= w_mm  | (w_mismatch_o  & ~clear_i);
      ar_mismatch_o <= ar_mm | (ar_mismatch_o & ~clear_i);
      timeout_o     <= timeout_hit | (timeout_o & {3{~clear_i}});
    end
  end

  assign mismatch_o = aw_mismatch_o | w_mismatch_o | ar_mismatch_o | (|timeout_o);
  assign busy_o     = (wr_cnt != '0) | (rd_cnt != '0)
                    | b_done_a | b_done_b | r_done_a | r_done_b
                    | axi_mst_a_req_i.aw_valid | axi_mst_a_req_i.w_valid | axi_mst_a_req_i.ar_valid
                    | axi_mst_b_req_i.aw_valid | axi_mst_b_req_i.w_valid | axi_mst_b_req_i.ar_valid;

  always_comb begin
    axi_slv_req_o          = axi_mst_a_req_i;
    axi_slv_req_o.aw_valid = aw_valid;
    axi_slv_req_o.w_valid  = w_valid;
    axi_slv_req_o.ar_valid = ar_valid;
    axi_slv_req_o.b_ready  = b_slv_ready;
    axi_slv_req_o.r_ready  = r_slv_ready;

    axi_mst_a_rsp_o          = axi_slv_rsp_i;
    axi_mst_a_rsp_o.aw_ready = aw_ready_a;
    axi_mst_a_rsp_o.w_ready  = w_ready_a;
    axi_mst_a_rsp_o.ar_ready = ar_ready_a;
    axi_mst_a_rsp_o.b_valid  = b_to_a;
    axi_mst_a_rsp_o.b        = b_beat;
    axi_mst_a_rsp_o.r_valid  = r_to_a;
    axi_mst_a_rsp_o.r        = r_beat;

    axi_mst_b_rsp_o          = axi_slv_rsp_i;
    axi_mst_b_rsp_o.aw_ready = aw_ready_b;
    axi_mst_b_rsp_o.w_ready  = w_ready_b;
    axi_mst_b_rsp_o.ar_ready = ar_ready_b;
    axi_mst_b_rsp_o.b_valid  = b_to_b;
    axi_mst_b_rsp_o.b        = b_beat;
    axi_mst_b_rsp_o.r_valid  = r_to_b;
    axi_mst_b_rsp_o.r        = r_beat;
  end

endmodule

// File: tb/tb_axi_master_compare.sv
// Directed-random bench for axi_master_compare (MaxTxns=2 so the outstanding cap is reachable).
module tb_axi_master_compare;
  import axi_master_compare_pkg::*;

  localparam int unsigned MaxTxns       = 2;
  localparam int unsigned TimeoutCycles = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  req_t       a_req, b_req, slv_req;
  rsp_t       a_rsp, b_rsp, slv_rsp;
  logic       aw_mm, w_mm, ar_mm, mm, busy;
  logic [2:0] to;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_master_compare #(
    .MaxTxns       (MaxTxns),
    .TimeoutCycles (TimeoutCycles)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .clear_i         (clear),
    .axi_mst_a_req_i (a_req),
    .axi_mst_a_rsp_o (a_rsp),
    .axi_mst_b_req_i (b_req),
    .axi_mst_b_rsp_o (b_rsp),
    .axi_slv_req_o   (slv_req),
    .axi_slv_rsp_i   (slv_rsp),
    .aw_mismatch_o   (aw_mm),
    .w_mismatch_o    (w_mm),
    .ar_mismatch_o   (ar_mm),
    .timeout_o       (to),
    .mismatch_o      (mm),
    .busy_o          (busy)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic aw_chan_t rand_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    logic [127:0] r;
    aw_chan_t x;
    r = rnd128();
    x = r[$bits(aw_chan_t)-1:0];
    x.id = id; x.addr = addr; x.len = len;
    return x;
  endfunction

  function automatic ar_chan_t rand_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    logic [127:0] r;
    ar_chan_t x;
    r = rnd128();
    x = r[$bits(ar_chan_t)-1:0];
    x.id = id; x.addr = addr; x.len = len;
    return x;
  endfunction

  function automatic w_chan_t rand_w(input logic last);
    logic [127:0] r;
    w_chan_t x;
    r = rnd128();
    x = r[$bits(w_chan_t)-1:0];
    x.last = last;
    return x;
  endfunction

  function automatic r_chan_t rand_r(input logic [3:0] id, input logic last);
    logic [127:0] r;
    r_chan_t x;
    r = rnd128();
    x = r[$bits(r_chan_t)-1:0];
    x.id = id; x.last = last;
    return x;
  endfunction

  initial begin
    aw_chan_t aw, aw2;
    ar_chan_t ar, arb;
    w_chan_t  w, wb;
    b_chan_t  bb;
    r_chan_t  rq[$], ra[$], rb[$];
    logic     done, ga, gb, exp_rdy;
    int       idx;

    a_req = '0; b_req = '0; slv_rsp = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_flags", 128'({aw_mm, w_mm, ar_mm, to, mm}), 128'(7'b0));
    check("rst_busy", 128'(busy), 128'(1'b0));
    check("rst_slv_valid", 128'({slv_req.aw_valid, slv_req.w_valid, slv_req.ar_valid}), 128'(3'b0));
    rst_n = 1'b1;
    tick();

    // 1: identical write burst, 4 W beats under random slave backpressure, one B to both
    aw = rand_aw(4'd3, 32'h1000, 8'd3);
    a_req.aw = aw; b_req.aw = aw;
    a_req.aw_valid = 1'b1; b_req.aw_valid = 1'b1; slv_rsp.aw_ready = 1'b1;
    #1;
    check("t1_aw_valid", 128'(slv_req.aw_valid), 128'(1'b1));
    check("t1_aw_payload", 128'(slv_req.aw), 128'(aw));
    check("t1_aw_ready_ab", 128'({a_rsp.aw_ready, b_rsp.aw_ready}), 128'(2'b11));
    tick();
    a_req.aw_valid = 1'b0; b_req.aw_valid = 1'b0; slv_rsp.aw_ready = 1'b0;
    #1;
    check("t1_busy_wr", 128'(busy), 128'(1'b1));
    for (int i = 0; i < 4; i++) begin
      w = rand_w(i == 3);
      a_req.w = w; b_req.w = w; a_req.w_valid = 1'b1; b_req.w_valid = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        slv_rsp.w_ready = 1'($urandom_range(0, 1));
        #1;
        check("t1_w_payload", 128'(slv_req.w), 128'(w));
        check("t1_w_valid", 128'({slv_req.w_valid, slv_req.aw_valid}), 128'(2'b10));
        check("t1_w_ready_a", 128'(a_rsp.w_ready), 128'(slv_rsp.w_ready));
        done = slv_rsp.w_ready;
        tick();
      end
      check("t1_w_bound", 128'(done), 128'(1'b1));
    end
    a_req.w_valid = 1'b0; b_req.w_valid = 1'b0; slv_rsp.w_ready = 1'b0;
    bb = '0; bb.id = 4'd3;
    slv_rsp.b = bb; slv_rsp.b_valid = 1'b1; a_req.b_ready = 1'b1; b_req.b_ready = 1'b1;
    #1;
    check("t1_b_valid_ab", 128'({a_rsp.b_valid, b_rsp.b_valid}), 128'(2'b11));
    check("t1_b_payload_a", 128'(a_rsp.b), 128'(bb));
    check("t1_b_payload_b", 128'(b_rsp.b), 128'(bb));
    check("t1_slv_b_ready", 128'(slv_req.b_ready), 128'(1'b1));
    tick();
    slv_rsp.b_valid = 1'b0; a_req.b_ready = 1'b0; b_req.b_ready = 1'b0;
    #1;
    check("t1_busy_idle", 128'(busy), 128'(1'b0));
    check("t1_no_flags", 128'(mm), 128'(1'b0));

    // 2: AR address divergence, then clear; W divergence while clear is held (set wins)
    ar = rand_ar(4'd5, 32'h2000, 8'd7);
    arb = ar; arb.addr = 32'h2004;
    a_req.ar = ar; b_req.ar = arb;
    a_req.ar_valid = 1'b1; b_req.ar_valid = 1'b1; slv_rsp.ar_ready = 1'b1;
    #1;
    check("t2_slv_ar_addr", 128'(slv_req.ar.addr), 128'(32'h2000));
    check("t2_slv_ar_payload", 128'(slv_req.ar), 128'(ar));
    check("t2_ar_mm_before", 128'(ar_mm), 128'(1'b0));
    tick();
    a_req.ar_valid = 1'b0; b_req.ar_valid = 1'b0; slv_rsp.ar_ready = 1'b0;
    #1;
    check("t2_ar_mm", 128'({ar_mm, mm, aw_mm, w_mm}), 128'(4'b1100));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t2_cleared", 128'({ar_mm, mm}), 128'(2'b00));
    w = rand_w(1'b1);
    wb = w; wb.data = w.data ^ (32'h1 << $urandom_range(0, 31));
    a_req.w = w; b_req.w = wb; a_req.w_valid = 1'b1; b_req.w_valid = 1'b1;
    slv_rsp.w_ready = 1'b1; clear = 1'b1;
    tick();
    a_req.w_valid = 1'b0; b_req.w_valid = 1'b0; slv_rsp.w_ready = 1'b0; clear = 1'b0;
    #1;
    check("t2_w_set_wins", 128'({w_mm, mm}), 128'(2'b11));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t2_w_cleared", 128'({w_mm, mm}), 128'(2'b00));

    // 4: 8-beat R burst answering the AR above; A always ready, B ready every 3rd cycle
    for (int i = 0; i < 8; i++) rq.push_back(rand_r(ar.id, i == 7));
    idx = 0; ga = 1'b0; gb = 1'b0;
    a_req.r_ready = 1'b1;
    for (int c = 0; c < 100 && idx < 8; c++) begin
      slv_rsp.r_valid = 1'b1; slv_rsp.r = rq[idx];
      b_req.r_ready = (c % 3 == 2);
      #1;
      exp_rdy = (ga | a_req.r_ready) & (gb | b_req.r_ready);
      check("t4_r_valid_a", 128'(a_rsp.r_valid), 128'(!ga));
      check("t4_r_valid_b", 128'(b_rsp.r_valid), 128'(!gb));
      check("t4_slv_r_ready", 128'(slv_req.r_ready), 128'(exp_rdy));
      if (a_rsp.r_valid && a_req.r_ready) ra.push_back(a_rsp.r);
      if (b_rsp.r_valid && b_req.r_ready) rb.push_back(b_rsp.r);
      if (exp_rdy) begin
        idx++; ga = 1'b0; gb = 1'b0;
      end else begin
        ga = ga | a_req.r_ready; gb = gb | b_req.r_ready;
      end
      tick();
    end
    slv_rsp.r_valid = 1'b0; b_req.r_ready = 1'b0;
    #1;
    check("t4_beats_sent", 128'(idx), 128'(8));
    check("t4_count_a", 128'(ra.size()), 128'(8));
    check("t4_count_b", 128'(rb.size()), 128'(8));
    for (int i = 0; i < 8; i++) begin
      if (i < ra.size()) check("t4_order_a", 128'(ra[i]), 128'(rq[i]));
      if (i < rb.size()) check("t4_order_b", 128'(rb[i]), 128'(rq[i]));
    end
    check("t4_busy_idle", 128'(busy), 128'(1'b0));

    // 5: read cap of 2 outstanding; third AR waits for the first last-R delivery
    slv_rsp.ar_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ar = rand_ar(4'(k), $urandom, 8'd0);
      a_req.ar = ar; b_req.ar = ar; a_req.ar_valid = 1'b1; b_req.ar_valid = 1'b1;
      #1;
      check("t5_ar_ready", 128'(a_rsp.ar_ready), 128'(k < 2));
      check("t5_slv_ar_valid", 128'(slv_req.ar_valid), 128'(k < 2));
      tick();
    end
    repeat (3) tick();
    check("t5_ar_still_blocked", 128'({a_rsp.ar_ready, b_rsp.ar_ready, slv_req.ar_valid}), 128'(3'b000));
    a_req.r_ready = 1'b1; b_req.r_ready = 1'b1;
    slv_rsp.r = rand_r(4'd0, 1'b1); slv_rsp.r_valid = 1'b1;
    #1;
    check("t5_r_deliver", 128'(slv_req.r_ready), 128'(1'b1));
    tick();
    slv_rsp.r_valid = 1'b0;
    #1;
    check("t5_ar_released", 128'({a_rsp.ar_ready, slv_req.ar_valid}), 128'(2'b11));
    tick();
    a_req.ar_valid = 1'b0; b_req.ar_valid = 1'b0; slv_rsp.ar_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      slv_rsp.r = rand_r(4'(k + 1), 1'b1); slv_rsp.r_valid = 1'b1;
      tick();
    end
    slv_rsp.r_valid = 1'b0; a_req.r_ready = 1'b0; b_req.r_ready = 1'b0;
    #1;
    check("t5_busy_idle", 128'(busy), 128'(1'b0));

    // 3: A holds AW alone; timeout lands after exactly TimeoutCycles cycles
    aw = rand_aw(4'd1, $urandom, 8'd0);
    a_req.aw = aw; a_req.aw_valid = 1'b1; slv_rsp.aw_ready = 1'b1;
    #1;
    check("t3_no_slv_aw", 128'({slv_req.aw_valid, a_rsp.aw_ready}), 128'(2'b00));
    repeat (TimeoutCycles - 1) tick();
    check("t3_timeout_early", 128'(to), 128'(3'b000));
    check("t3_no_slv_aw_late", 128'(slv_req.aw_valid), 128'(1'b0));
    tick();
    check("t3_timeout", 128'({to, mm}), 128'(4'b0011));
    b_req.aw = aw; b_req.aw_valid = 1'b1;
    #1;
    check("t3_slv_aw_after_b", 128'(slv_req.aw_valid), 128'(1'b1));
    tick();
    a_req.aw_valid = 1'b0; b_req.aw_valid = 1'b0;
    #1;
    check("t3_timeout_sticky", 128'(to), 128'(3'b001));

    // 6: AW handshake coinciding with B delivery leaves one write outstanding
    aw2 = rand_aw(4'd2, $urandom, 8'd0);
    a_req.aw = aw2; b_req.aw = aw2; a_req.aw_valid = 1'b1; b_req.aw_valid = 1'b1;
    slv_rsp.b = '0; slv_rsp.b_valid = 1'b1; a_req.b_ready = 1'b1; b_req.b_ready = 1'b1;
    #1;
    check("t6_simul_aw_ready", 128'(a_rsp.aw_ready), 128'(1'b1));
    check("t6_simul_b_ready", 128'(slv_req.b_ready), 128'(1'b1));
    tick();
    slv_rsp.b_valid = 1'b0; a_req.b_ready = 1'b0; b_req.b_ready = 1'b0;
    #1;
    check("t6_cnt_one_left", 128'(a_rsp.aw_ready), 128'(1'b1));
    tick();
    check("t6_cap_reached", 128'({a_rsp.aw_ready, slv_req.aw_valid}), 128'(2'b00));
    slv_rsp.r = rand_r(4'd7, 1'b0); slv_rsp.r_valid = 1'b1;
    a_req.r_ready = 1'b1; b_req.r_ready = 1'b0;
    tick();
    check("t6_partial_r", 128'({a_rsp.r_valid, b_rsp.r_valid}), 128'(2'b01));
    rst_n = 1'b0;
    a_req = '0; b_req = '0; slv_rsp = '0;
    #1;
    check("t6_rst_flags", 128'({aw_mm, w_mm, ar_mm, to, mm}), 128'(7'b0));
    check("t6_rst_busy", 128'(busy), 128'(1'b0));
    check("t6_rst_slv", 128'({slv_req.aw_valid, slv_req.w_valid, slv_req.ar_valid, slv_req.b_ready, slv_req.r_ready}), 128'(5'b0));
    tick();
    rst_n = 1'b1;
    tick();
    slv_rsp.r_valid = 1'b1;
    a_req.aw = aw2; b_req.aw = aw2; a_req.aw_valid = 1'b1; b_req.aw_valid = 1'b1; slv_rsp.aw_ready = 1'b1;
    #1;
    check("t6_post_rst_fork", 128'({a_rsp.r_valid, b_rsp.r_valid}), 128'(2'b11));
    check("t6_post_rst_cnt", 128'(a_rsp.aw_ready), 128'(1'b1));
    a_req = '0; b_req = '0; slv_rsp = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
